// File: rtl/pu_master_spi_driver_pkg.sv
// Shared SPI state codes and state type, used by both SPI endpoints.
package pu_master_spi_driver_pkg;

    localparam logic [2:0] SPI_ST_IDLE      = 3'd0;
    localparam logic [2:0] SPI_ST_CS_SETUP  = 3'd1;
    localparam logic [2:0] SPI_ST_SCLK_HIGH = 3'd2;
    localparam logic [2:0] SPI_ST_SCLK_LOW  = 3'd3;
    localparam logic [2:0] SPI_ST_CS_HOLD   = 3'd4;
    localparam logic [2:0] SPI_ST_GAP       = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = SPI_ST_IDLE,
        ST_CS_SETUP  = SPI_ST_CS_SETUP,
        ST_SCLK_HIGH = SPI_ST_SCLK_HIGH,
        ST_SCLK_LOW  = SPI_ST_SCLK_LOW,
        ST_CS_HOLD   = SPI_ST_CS_HOLD,
        ST_GAP       = SPI_ST_GAP
    } spi_state_e;

endpackage

// File: rtl/pu_spi_halfperiod_timer.sv
// Half-period timer: tick_c is high on the last cycle of every HALF-cycle window.
// The window restarts whenever clr is high.
module pu_spi_halfperiod_timer #(
    parameter int unsigned HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CW = $clog2(HALF + 1);

    logic [CW-1:0] cnt;

    assign tick_c = (cnt == CW'(HALF - 1));

    // Count cycles within the current window, wrapping on the tick.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pu_master_spi_driver.sv
// SPI master, mode CPOL=0 / CPHA=1: mosi launched on sclk rise, miso sampled on sclk fall.
module pu_master_spi_driver
    import pu_master_spi_driver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned SCLK_HALFPERIOD = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs
);

    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);

    spi_state_e            state;
    logic [DATA_WIDTH-1:0] shift;
    logic [BW-1:0]         bit_cnt;
    logic [BW-1:0]         bit_cnt_nxt_c;
    logic                  tmr_clr_c;
    logic                  tick_c;

    // The timer is held cleared while idle so every transaction starts on a fresh window.
    assign tmr_clr_c     = (state == ST_IDLE);
    assign bit_cnt_nxt_c = bit_cnt + BW'(1);

    pu_spi_halfperiod_timer #(
        .HALF (SCLK_HALFPERIOD)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr_c),
        .tick_c (tick_c)
    );

    // Transaction sequencer with registered SPI pins and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            cs       <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            data_out <= '0;
            shift    <= '0;
            bit_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift   <= data_in;
                        cs      <= 1'b0;
                        ready   <= 1'b0;
                        bit_cnt <= '0;
                        state   <= ST_CS_SETUP;
                    end
                end
                ST_CS_SETUP, ST_SCLK_LOW: begin
                    if (tick_c) begin
                        sclk  <= 1'b1;
                        mosi  <= shift[DATA_WIDTH-1];
                        state <= ST_SCLK_HIGH;
                    end
                end
                ST_SCLK_HIGH: begin
                    if (tick_c) begin
                        sclk    <= 1'b0;
                        shift   <= {shift[DATA_WIDTH-2:0], miso};
                        bit_cnt <= bit_cnt_nxt_c;
                        if (bit_cnt_nxt_c == BW'(DATA_WIDTH)) begin
                            state <= ST_CS_HOLD;
                        end else begin
                            state <= ST_SCLK_LOW;
                        end
                    end
                end
                ST_CS_HOLD: begin
                    if (tick_c) begin
                        cs       <= 1'b1;
                        mosi     <= 1'b0;
                        data_out <= shift;
                        done     <= 1'b1;
                        state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tick_c) begin
                        ready <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    cs    <= 1'b1;
                    sclk  <= 1'b0;
                    mosi  <= 1'b0;
                end
            endcase
        end
    end

endmodule
